// File: rtl/seq_requester_pkg.sv
// seq_requester_pkg
//   Shared definitions for the sequence requester: response status codes,
//   requester FSM states and the operand widths used by the sequence
//   generator it drives.
package seq_requester_pkg;

  localparam int ORDER_W = 16;
  localparam int DATA_W  = 64;

  typedef logic [ORDER_W-1:0] seq_order_t;
  typedef logic [DATA_W-1:0]  seq_data_t;

  typedef enum logic [1:0] {
    STATUS_OK  = 2'd0,
    STATUS_OVF = 2'd1,
    STATUS_ERR = 2'd2,
    STATUS_TMO = 2'd3
  } seq_status_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD1 = 3'd1,
    S_LOAD2 = 3'd2,
    S_WAIT  = 3'd3,
    S_CLEAR = 3'd4,
    S_RESP  = 3'd5
  } req_state_t;

endpackage

// File: rtl/seq_requester.sv
// seq_requester
//   Command-side driver for the sequence generator. Takes one request at a
//   time (valid/ready), applies a 2-cycle load pulse with the selected mode
//   and operands, waits for done/overflow/error, clears the generator when
//   it stopped on a fault, and returns one response (valid/ready).
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_fib, req_tri          requested mode (exactly one must be set)
//   req_order, req_seed       Nth term and initial value
//   rsp_valid/rsp_ready       response handshake
//   rsp_data, rsp_status      result (0 unless OK) and seq_status_t
//   gen_fibonacci/triangle    generator mode pins
//   gen_load, gen_clear       generator load pulse / clear pulse
//   gen_order, gen_data_in    generator operands
//   gen_done, gen_data_out    generator completion pulse and result
//   gen_overflow, gen_error   generator fault levels
//
// Configuration
//   SEQ_REQ_TIMEOUT_EN  when defined, WAIT aborts with status TMO after
//                       TIMEOUT_CYCLES cycles without a generator event.
module seq_requester
  import seq_requester_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_fib,
  input  logic              req_tri,
  input  logic [15:0]       req_order,
  input  logic [63:0]       req_seed,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_data,
  output logic [1:0]        rsp_status,
  output logic              gen_fibonacci,
  output logic              gen_triangle,
  output logic              gen_load,
  output logic              gen_clear,
  output logic [15:0]       gen_order,
  output logic [63:0]       gen_data_in,
  input  logic              gen_done,
  input  logic [63:0]       gen_data_out,
  input  logic              gen_overflow,
  input  logic              gen_error
);

  req_state_t  state_q, state_d;
  seq_status_t status_q, status_d;
  seq_data_t   result_q, result_d;
  seq_order_t  order_q;
  seq_data_t   seed_q;
  logic        fib_q, tri_q;
  logic        capture;

`ifdef SEQ_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_hit;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    result_d = result_q;
    capture  = 1'b0;
`ifdef SEQ_REQ_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          capture  = 1'b1;
          result_d = '0;
          // Illegal mode combinations answer directly without touching
          // the generator.
          if (req_fib ^ req_tri) begin
            state_d = S_LOAD1;
          end else begin
            status_d = STATUS_ERR;
            state_d  = S_RESP;
          end
        end
      end
      S_LOAD1: state_d = S_LOAD2;
      S_LOAD2: begin
        state_d = S_WAIT;
`ifdef SEQ_REQ_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
`ifdef SEQ_REQ_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        // Priority error > overflow > done; the generator returns to idle
        // by itself after done, so only faults need a clear.
        if (gen_error) begin
          status_d = STATUS_ERR;
          state_d  = S_CLEAR;
        end else if (gen_overflow) begin
          status_d = STATUS_OVF;
          state_d  = S_CLEAR;
        end else if (gen_done) begin
          status_d = STATUS_OK;
          result_d = gen_data_out;
          state_d  = S_RESP;
        end
`ifdef SEQ_REQ_TIMEOUT_EN
        else if (timeout_hit) begin
          status_d = STATUS_TMO;
          state_d  = S_CLEAR;
        end
`endif
      end
      S_CLEAR: state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      status_q <= STATUS_OK;
`ifdef SEQ_REQ_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
`ifdef SEQ_REQ_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Operand and result registers; every output using them is gated by
  // state, so they need no reset.
  always_ff @(posedge clk) begin
    result_q <= result_d;
    if (capture) begin
      fib_q   <= req_fib;
      tri_q   <= req_tri;
      order_q <= req_order;
      seed_q  <= req_seed;
    end
  end

  // Moore output decode: state and registered data only.
  logic drive_mode, drive_ops;
  assign drive_mode = (state_q == S_LOAD1) || (state_q == S_LOAD2) || (state_q == S_WAIT);
  assign drive_ops  = drive_mode || (state_q == S_CLEAR);

  assign req_ready     = (state_q == S_IDLE);
  assign rsp_valid     = (state_q == S_RESP);
  assign rsp_data      = rsp_valid ? result_q : '0;
  assign rsp_status    = rsp_valid ? status_q : STATUS_OK;
  assign gen_load      = (state_q == S_LOAD1) || (state_q == S_LOAD2);
  assign gen_clear     = (state_q == S_CLEAR);
  assign gen_fibonacci = drive_mode && fib_q;
  assign gen_triangle  = drive_mode && tri_q;
  assign gen_order     = drive_ops ? order_q : '0;
  assign gen_data_in   = drive_ops ? seed_q : '0;

endmodule

// File: doc/seq_requester.md
# seq_requester

Command-side driver for the sequence generator. Accepts one sequence request at a time on a valid/ready interface and drives the generator's load/mode/order/data_in pins with the required 2-cycle load pulse. It then waits for done, overflow or error, issues clear where the generator needs it, and returns one response (result plus status) on a valid/ready response interface. It sits between the test/host logic and the generator, which is wired port-to-port beside it.

## Interface
- TIMEOUT_CYCLES, 1024: maximum WAIT cycles before abort; legal range ≥ 2; used only with SEQ_REQ_TIMEOUT_EN.
- clk  input  1  clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  high exactly in IDLE.
- req_fib  input  1  request Fibonacci mode.
- req_tri  input  1  request triangle mode.
- req_order  input  16  Nth term requested.
- req_seed  input  64  initial value.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumer ready.
- rsp_data  output  64  result; 0 unless status OK.
- rsp_status  output  2  seq_status_t.
- gen_fibonacci  output  1  generator mode pin.
- gen_triangle  output  1  generator mode pin.
- gen_load  output  1  generator load.
- gen_clear  output  1  generator clear.
- gen_order  output  16  generator order.
- gen_data_in  output  64  generator seed.
- gen_done  input  1  generator done pulse.
- gen_data_out  input  64  generator result.
- gen_overflow  input  1  generator overflow (level).
- gen_error  input  1  generator error (level).

## Operation
- States (req_state_t): IDLE, LOAD1, LOAD2, WAIT, CLEAR, RESP.
- IDLE: a request is accepted when req_valid && req_ready. On accept, req_fib, req_tri, req_order and req_seed are registered.
  - Exactly one of req_fib/req_tri set: go to LOAD1.
  - Neither or both set: go to RESP with status ERR and rsp_data 0. The generator is never touched.
- LOAD1, LOAD2: gen_load=1. The selected mode pin is 1. gen_order and gen_data_in hold the registered values, stable across both cycles.
- WAIT: gen_load=0. The mode pin and operands stay held. Events are checked with priority gen_error > gen_overflow > gen_done.
  - gen_error: status ERR, go to CLEAR.
  - gen_overflow: status OVF, go to CLEAR.
  - gen_done: capture gen_data_out, status OK, go to RESP. No clear is needed because the generator self-returns to idle after done.
- CLEAR: gen_clear=1 for exactly one cycle. Mode pins drop to 0. Go to RESP.
- RESP: rsp_valid=1. rsp_data and rsp_status are stable until the cycle where rsp_ready=1, then go to IDLE.
- Generator inputs are ignored outside WAIT.
- All gen_* outputs are 0 in IDLE and RESP.

## Timing
- Reset (async assert): state IDLE. All outputs 0, except req_ready, which is 1 as a decode of IDLE. Any request accepted while reset_n is low is ignored. Captured data is discarded.
- Reset mid-transaction aborts with no response. The system ties the generator's reset to the same source.
- Accept at cycle T: gen_load high at T+1 and T+2. WAIT begins at T+3.
- A generator error on a bad operand is visible at T+3 or later.
- Event sampled at WAIT cycle W:
  - done: rsp_valid at W+1.
  - error/overflow: gen_clear at W+1, rsp_valid at W+2.
- Illegal mode accepted at T: rsp_valid at T+1.
- Back-to-back: after the response handshake at cycle R, IDLE is at R+1 and the next accept is possible at R+1.
- All outputs are Moore: decoded from state and registered data only. There is no combinational path from gen_* inputs or from rsp_ready to any output.

## Configuration
- SEQ_REQ_TIMEOUT_EN defined: a WAIT-cycle counter of width $clog2(TIMEOUT_CYCLES+1) is included.
  - The counter is zeroed on entry to WAIT and increments each WAIT cycle.
  - In the WAIT cycle where count == TIMEOUT_CYCLES-1 and no event is present, go to CLEAR with status TMO.
  - An event in that same cycle wins over the timeout.
- Not defined: no counter. WAIT lasts indefinitely, TMO is never produced, and TIMEOUT_CYCLES is unused.

## Structure
- Shared definitions package holds:
  - seq_status_t: 2-bit, OK=0, OVF=1, ERR=2, TMO=3.
  - req_state_t.
  - The 16/64-bit operand typedefs already used by the generator.
- Single flat module, no sub-modules. The timeout counter is an inline `ifdef` block.

## Test plan
- Fib request, order 10, seed 1. Generator model asserts done at WAIT cycle 5 with data_out 0x37 → gen_load high exactly 2 cycles; response OK, 0x37 at W+1; gen_clear never asserted.
- Triangle request, order 0. Model raises error at T+3 → gen_clear 1 cycle at T+4; response ERR, data 0 at T+5.
- Fib request. Model holds overflow → one-cycle clear, response OVF. Hold rsp_ready=0 for 4 cycles → rsp_valid/rsp_data/rsp_status stable throughout; req_ready=0 throughout.
- req_fib=1 and req_tri=1 together → response ERR at T+1; gen_load never asserted.
- With SEQ_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, model silent → clear at WAIT cycle 8, response TMO.
  - Repeat with done on WAIT cycle 8 (count 7) → OK.
- reset_n pulsed low during WAIT → all outputs 0 asynchronously, no response emitted; a new request is accepted after release.
